vending_machine: RTL and testbench
==================================

VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 Parameter PRICE0, default 8'd20: price of item 0, in rupees.
REQ-002 Parameter PRICE1, default 8'd35: price of item 1.
REQ-003 Parameter PRICE2, default 8'd50: price of item 2.
REQ-004 Parameter PRICE3, default 8'd45: price of item 3.
REQ-005 Parameter INIT_STOCK, default 4'd5: stock loaded into every item on reset.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 item_select  input  2  selected item, 0-3.
REQ-009 money_in  input  8  amount inserted this cycle; 0 means no insertion.
REQ-010 cancel  input  1  abort transaction and refund the balance.
REQ-011 dispense  output  1  registered one-cycle pulse; item delivered.
REQ-012 change  output  8  registered amount returned; valid only in its cycle, otherwise 0.
REQ-013 money_needed  output  8  combinational: remaining amount for the selected item.
REQ-014 stock  output  4  combinational: stock of the selected item.

Function
REQ-015 Internal state SHALL be: 8-bit balance register, stock array stocks[0..3] (4 bits each), constant price table prices[0..3]; stocks and prices SHALL be hierarchically accessible under those names.
REQ-016 Each clock edge, with reset=0, the block SHALL evaluate in priority order: cancel, then insertion/purchase.
REQ-017 Cancel: when cancel=1 and balance>0, change SHALL be balance for one cycle, balance SHALL clear, and money_in that cycle SHALL also be refunded (added to change); dispense SHALL be 0.
REQ-018 When cancel=1 and balance=0, change SHALL equal money_in; no other effect.
REQ-019 Let sum = balance + money_in, computed 9 bits wide; if sum > 255, money_in SHALL be rejected: change=money_in, balance unchanged.
REQ-020 Purchase: if sum >= prices[item_select] and stocks[item_select] > 0, then next cycle dispense=1, change = sum - price, balance=0, stocks[item_select] decrements by 1.
REQ-021 If sum < price, balance SHALL become sum; dispense=0, change=0.
REQ-022 If stocks[item_select]=0, money_in SHALL be returned as change the next cycle, balance SHALL be unchanged, and dispense SHALL stay 0.
REQ-023 A purchase SHALL also trigger with money_in=0 when the existing balance covers the currently selected item and stock > 0, e.g. after item_select changes to a cheaper item.
REQ-024 Balance SHALL be retained across item_select changes; price comparison always uses the current selection.
REQ-025 money_needed SHALL be prices[item_select] - balance when balance < price, else 0.
REQ-026 stock SHALL equal stocks[item_select].
REQ-027 dispense and change SHALL return to 0 on the cycle after any nonzero pulse, unless a new event occurs.
REQ-028 Stock SHALL never wrap below 0; no restock input exists other than reset.

Reset
REQ-029 On a clock edge with reset=1: balance=0, stocks[0..3]=INIT_STOCK, dispense=0, change=0; inputs SHALL be ignored that cycle.
REQ-030 Reset mid-transaction SHALL discard the balance without a refund.
REQ-031 After reset: money_needed = prices[item_select]; stock = INIT_STOCK.

Verification
REQ-032 Reset, then select 1 and insert 20 for one cycle -> money_needed=15, dispense=0, change=0.
REQ-033 Then insert 15 -> next edge dispense=1 for one cycle, change=0, stock 5->4, money_needed returns to 35.
REQ-034 Select 2, insert 30, then hold cancel=1 for 2 cycles -> first cancel cycle change=30, then 0; money_needed=50; no dispense.
REQ-035 Select 3, insert 50 in one cycle -> dispense=1, change=5, stock(3)=4.
REQ-036 Buy item 0 five times at exact price, then insert 20 again -> stock=0, dispense=0, change=20 returned.
REQ-037 Insert 200 then 100 on item 2 with stock>0 -> purchase fires on first insertion (change 150); separately, balance 200 plus 100 -> 100 rejected as change.

Source files
------------

// File: rtl/vending_machine.sv
// Four-item vending machine: accumulates coins into a balance, dispenses when the
// selected item is covered and in stock, and refunds on cancel, overflow or sell-out.
module vending_machine #(
  parameter logic [7:0] PRICE0     = 8'd20,
  parameter logic [7:0] PRICE1     = 8'd35,
  parameter logic [7:0] PRICE2     = 8'd50,
  parameter logic [7:0] PRICE3     = 8'd45,
  parameter logic [3:0] INIT_STOCK = 4'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] item_select,
  input  logic [7:0] money_in,
  input  logic       cancel,
  output logic       dispense,
  output logic [7:0] change,
  output logic [7:0] money_needed,
  output logic [3:0] stock
);

  localparam int unsigned MONEY_W = 8;
  localparam int unsigned STOCK_W = 4;
  localparam int unsigned N_ITEMS = 4;

  localparam logic [MONEY_W-1:0] prices [N_ITEMS] = '{PRICE0, PRICE1, PRICE2, PRICE3};

  logic [MONEY_W-1:0] balance;
  logic [STOCK_W-1:0] stocks [N_ITEMS];

  logic [MONEY_W-1:0] balance_nxt;
  logic [STOCK_W-1:0] stocks_nxt [N_ITEMS];
  logic               dispense_nxt;
  logic [MONEY_W-1:0] change_nxt;

  logic [MONEY_W:0]   sum;
  logic [MONEY_W-1:0] price_sel;
  logic [STOCK_W-1:0] stock_sel;

  assign sum       = {1'b0, balance} + {1'b0, money_in};
  assign price_sel = prices[item_select];
  assign stock_sel = stocks[item_select];

  // Selection-view outputs follow the current item immediately.
  assign money_needed = (balance < price_sel) ? (price_sel - balance) : '0;
  assign stock        = stock_sel;

  // Transaction decision: cancel first, then overflow / sell-out / purchase / accumulate.
  always_comb begin
    balance_nxt  = balance;
    stocks_nxt   = stocks;
    dispense_nxt = 1'b0;
    change_nxt   = '0;

    if (cancel) begin
      change_nxt  = MONEY_W'(sum);
      balance_nxt = '0;
    end else if (sum[MONEY_W] || (stock_sel == '0)) begin
      change_nxt = money_in;
    end else if (MONEY_W'(sum) >= price_sel) begin
      dispense_nxt            = 1'b1;
      change_nxt              = MONEY_W'(sum - {1'b0, price_sel});
      balance_nxt             = '0;
      stocks_nxt[item_select] = stock_sel - STOCK_W'(1);
    end else begin
      balance_nxt = MONEY_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      balance  <= '0;
      dispense <= 1'b0;
      change   <= '0;
      for (int i = 0; i < N_ITEMS; i++) stocks[i] <= INIT_STOCK;
    end else begin
      balance  <= balance_nxt;
      dispense <= dispense_nxt;
      change   <= change_nxt;
      for (int i = 0; i < N_ITEMS; i++) stocks[i] <= stocks_nxt[i];
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: default-priced instance plus a high-priced
// instance used to hold a large balance for the overflow case.
module tb_vending_machine;

  logic       clk;
  logic       reset;
  logic [1:0] item_select;
  logic [7:0] money_in;
  logic       cancel;
  logic       dispense;
  logic [7:0] change;
  logic [7:0] money_needed;
  logic [3:0] stock;

  logic       h_reset;
  logic [1:0] h_sel;
  logic [7:0] h_money;
  logic       h_cancel;
  logic       h_dispense;
  logic [7:0] h_change;
  logic [7:0] h_needed;
  logic [3:0] h_stock;

  int n_cmp = 0;
  int n_err = 0;

  vending_machine dut (
    .clk(clk), .reset(reset), .item_select(item_select), .money_in(money_in),
    .cancel(cancel), .dispense(dispense), .change(change),
    .money_needed(money_needed), .stock(stock)
  );

  vending_machine #(.PRICE2(8'd250)) dut_hi (
    .clk(clk), .reset(h_reset), .item_select(h_sel), .money_in(h_money),
    .cancel(h_cancel), .dispense(h_dispense), .change(h_change),
    .money_needed(h_needed), .stock(h_stock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then return money/cancel to idle and settle.
  task automatic cycle(input logic [1:0] sel, input logic [7:0] money, input logic canc);
    item_select = sel;
    money_in    = money;
    cancel      = canc;
    @(posedge clk);
    #1;
    money_in = '0;
    cancel   = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; item_select = 2'd1; money_in = '0; cancel = 1'b0;
    h_reset = 1'b1; h_sel = 2'd2; h_money = '0; h_cancel = 1'b0;

    cycle(2'd1, 8'd0, 1'b0);
    reset = 1'b0; h_reset = 1'b0;
    chk("rst_dispense", dispense, 0);
    chk("rst_change", change, 0);
    chk("rst_needed", money_needed, 35);
    chk("rst_stock", stock, 5);

    cycle(2'd1, 8'd20, 1'b0);
    chk("ins20_needed", money_needed, 15);
    chk("ins20_dispense", dispense, 0);
    chk("ins20_change", change, 0);

    cycle(2'd1, 8'd15, 1'b0);
    chk("buy1_dispense", dispense, 1);
    chk("buy1_change", change, 0);
    chk("buy1_stock", stock, 4);
    chk("buy1_needed", money_needed, 35);

    cycle(2'd1, 8'd0, 1'b0);
    chk("pulse_end_dispense", dispense, 0);
    chk("pulse_end_change", change, 0);

    cycle(2'd2, 8'd30, 1'b0);
    chk("ins30_needed", money_needed, 20);
    cycle(2'd2, 8'd0, 1'b1);
    chk("cancel1_change", change, 30);
    chk("cancel1_dispense", dispense, 0);
    cycle(2'd2, 8'd0, 1'b1);
    chk("cancel2_change", change, 0);
    chk("cancel2_needed", money_needed, 50);
    chk("cancel2_dispense", dispense, 0);

    cycle(2'd3, 8'd50, 1'b0);
    chk("buy3_dispense", dispense, 1);
    chk("buy3_change", change, 5);
    chk("buy3_stock", stock, 4);

    // Balance held on item 2, then switching to cheaper item 0 buys with no coin.
    cycle(2'd2, 8'd40, 1'b0);
    chk("ins40_needed", money_needed, 10);
    chk("ins40_dispense", dispense, 0);
    cycle(2'd0, 8'd0, 1'b0);
    chk("switch_dispense", dispense, 1);
    chk("switch_change", change, 20);
    chk("switch_stock", stock, 4);

    for (int i = 0; i < 4; i++) begin
      cycle(2'd0, 8'd20, 1'b0);
      chk("buy0_dispense", dispense, 1);
      chk("buy0_change", change, 0);
      chk("buy0_stock", stock, 3 - i);
    end
    cycle(2'd0, 8'd20, 1'b0);
    chk("soldout_dispense", dispense, 0);
    chk("soldout_change", change, 20);
    chk("soldout_stock", stock, 0);
    chk("soldout_needed", money_needed, 20);

    cycle(2'd1, 8'd10, 1'b0);
    chk("bal10_needed", money_needed, 25);
    cycle(2'd1, 8'd5, 1'b1);
    chk("cancel_plus_coin_change", change, 15);
    chk("cancel_plus_coin_needed", money_needed, 35);

    cycle(2'd2, 8'd200, 1'b0);
    chk("big200_dispense", dispense, 1);
    chk("big200_change", change, 150);
    cycle(2'd2, 8'd100, 1'b0);
    chk("big100_dispense", dispense, 1);
    chk("big100_change", change, 50);
    chk("big_stock2", stock, 3);

    // Reset mid-transaction drops the balance without refund and restocks.
    cycle(2'd1, 8'd10, 1'b0);
    chk("pre_rst_needed", money_needed, 25);
    reset = 1'b1;
    cycle(2'd1, 8'd30, 1'b0);
    reset = 1'b0;
    chk("midrst_change", change, 0);
    chk("midrst_dispense", dispense, 0);
    chk("midrst_needed", money_needed, 35);
    chk("midrst_stock1", stock, 5);
    cycle(2'd0, 8'd0, 1'b0);
    chk("midrst_stock0", stock, 5);

    // Overflow: balance 200 plus 100 exceeds 255, so the 100 is rejected.
    h_money = 8'd200;
    @(posedge clk); #1;
    h_money = '0; #1;
    chk("hi_bal200_needed", h_needed, 50);
    chk("hi_bal200_dispense", h_dispense, 0);
    chk("hi_bal200_change", h_change, 0);
    h_money = 8'd100;
    @(posedge clk); #1;
    h_money = '0; #1;
    chk("hi_ovf_change", h_change, 100);
    chk("hi_ovf_dispense", h_dispense, 0);
    chk("hi_ovf_needed", h_needed, 50);
    chk("hi_ovf_stock", h_stock, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
